// File: rtl/debounce_sync_filter_if.sv
// Level/pulse bundle between a raw pin source and the debounce filter.
interface debounce_sync_filter_if;
  logic data_i;
  logic level_o;
  logic rise_o;
  logic fall_o;

  modport master (
    output data_i,
    input  level_o,
    input  rise_o,
    input  fall_o
  );

  modport slave (
    input  data_i,
    output level_o,
    output rise_o,
    output fall_o
  );
endinterface

// File: rtl/debounce_sync_filter.sv
// Synchronizer plus stable-count debounce FSM with registered level/edge outputs.
// Define DEBOUNCE_EDGE_PULSE_EN to build the rise_o/fall_o pulse logic.
module debounce_sync_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CNT  = 16,
  parameter int CNT_W       = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  debounce_sync_filter_if.slave bus
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES must be 2..4");
  end
  if (STABLE_CNT < 1 || STABLE_CNT > 255) begin : g_bad_cnt
    $error("STABLE_CNT must be 1..255");
  end
  if (CNT_W < $clog2(STABLE_CNT + 1) || CNT_W > 32) begin : g_bad_w
    $error("CNT_W too narrow for STABLE_CNT");
  end

  typedef enum logic [1:0] {
    LOW_STABLE,
    LOW_PEND,
    HIGH_STABLE,
    HIGH_PEND
  } state_e;

  localparam logic [CNT_W-1:0] LAST  = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [2:0]       BLANK = 3'(SYNC_STAGES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;

  // Plain followers: the first stage may go metastable, so no reset here.
  always_ff @(posedge clk_i) begin
    sync_q <= {sync_q[SYNC_STAGES-2:0], bus.data_i};
  end

  assign sync = sync_q[SYNC_STAGES-1];

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       blank_q, blank_d;
  logic             level_q, level_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    blank_d = blank_q;
    // Ignore sync until the chain has refilled after reset.
    if (blank_q != 3'd0) begin
      blank_d = blank_q - 3'd1;
      state_d = LOW_STABLE;
    end else begin
      unique case (state_q)
        LOW_STABLE: begin
          if (sync) begin
            if (STABLE_CNT == 1) begin
              state_d = HIGH_STABLE;
            end else begin
              state_d = LOW_PEND;
              cnt_d   = ONE;
            end
          end
        end
        LOW_PEND: begin
          if (!sync) begin
            state_d = LOW_STABLE;
          end else if (cnt_q == LAST) begin
            state_d = HIGH_STABLE;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        HIGH_STABLE: begin
          if (!sync) begin
            if (STABLE_CNT == 1) begin
              state_d = LOW_STABLE;
            end else begin
              state_d = HIGH_PEND;
              cnt_d   = ONE;
            end
          end
        end
        HIGH_PEND: begin
          if (sync) begin
            state_d = HIGH_STABLE;
          end else if (cnt_q == LAST) begin
            state_d = LOW_STABLE;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        default: state_d = LOW_STABLE;
      endcase
    end
    level_d = (state_d == HIGH_STABLE) || (state_d == HIGH_PEND);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= LOW_STABLE;
      cnt_q   <= '0;
      blank_q <= BLANK;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blank_q <= blank_d;
      level_q <= level_d;
    end
  end

  assign bus.level_o = level_q;

`ifdef DEBOUNCE_EDGE_PULSE_EN
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    rise_d = level_d & ~level_q;
    fall_d = ~level_d & level_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign bus.rise_o = rise_q;
  assign bus.fall_o = fall_q;
`else
  assign bus.rise_o = 1'b0;
  assign bus.fall_o = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_sync_filter.sv
// Bench: default filter driven from a segment table, plus a 3-stage/1-count
// instance exercised by a hand-written pulse sequence.
module tb_debounce_sync_filter;

`ifdef DEBOUNCE_EDGE_PULSE_EN
  localparam bit P = 1'b1;
`else
  localparam bit P = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  debounce_sync_filter_if ifa ();
  debounce_sync_filter_if ifb ();

  debounce_sync_filter dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifa.slave)
  );

  debounce_sync_filter #(
    .SYNC_STAGES (3),
    .STABLE_CNT  (1),
    .CNT_W       (1)
  ) dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifb.slave)
  );

  typedef struct {
    bit rst;
    bit d;
    int n;
    bit lvl;
    bit rise;
    bit fall;
  } vec_t;

  typedef struct {
    int id;
    bit on_b;
    bit lvl;
    bit rise;
    bit fall;
  } exp_t;

  vec_t tbl [17];
  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input int id, input bit act, input bit exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %b want %b", nm, id, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit da, input bit db);
    exp_t e;
    rst = r;
    ifa.data_i = da;
    ifb.data_i = db;
    @(posedge clk);
    #1;
    chk("a_excl", 0, ifa.rise_o & ifa.fall_o, 1'b0);
    chk("b_excl", 0, ifb.rise_o & ifb.fall_o, 1'b0);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.on_b) begin
        chk("b_level", e.id, ifb.level_o, e.lvl);
        chk("b_rise", e.id, ifb.rise_o, e.rise);
        chk("b_fall", e.id, ifb.fall_o, e.fall);
      end else begin
        chk("a_level", e.id, ifa.level_o, e.lvl);
        chk("a_rise", e.id, ifa.rise_o, e.rise);
        chk("a_fall", e.id, ifa.fall_o, e.fall);
      end
    end
  endtask

  initial begin
    bit bd [7];
    bit bl [7];
    bit br [7];
    bit bf [7];

    // reset, then held 1: rises on edge 18
    tbl[0]  = '{1'b1, 1'b0,  3, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 17, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1,  1, 1'b1, P,    1'b0};
    tbl[3]  = '{1'b0, 1'b1,  1, 1'b1, 1'b0, 1'b0};
    // 15 low, 1 high bounce, then low held: falls 18 edges later
    tbl[4]  = '{1'b0, 1'b0, 15, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1,  1, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 17, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0,  1, 1'b0, 1'b0, P   };
    tbl[8]  = '{1'b0, 1'b0,  1, 1'b0, 1'b0, 1'b0};
    // short high pulse is rejected
    tbl[9]  = '{1'b0, 1'b1, 10, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 20, 1'b0, 1'b0, 1'b0};
    // reset at cnt=9 in LOW_PEND, then clean restart
    tbl[11] = '{1'b0, 1'b1, 11, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b1,  1, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 17, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b1,  1, 1'b1, P,    1'b0};
    tbl[15] = '{1'b0, 1'b0, 17, 1'b1, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b0,  1, 1'b0, 1'b0, P   };

    ifa.data_i = 1'b0;
    ifb.data_i = 1'b0;

    for (int v = 0; v < 17; v++) begin
      for (int i = 0; i < tbl[v].n; i++) begin
        if (i == tbl[v].n - 1)
          sb.push_back('{v, 1'b0, tbl[v].lvl, tbl[v].rise, tbl[v].fall});
        step(tbl[v].rst, tbl[v].d, 1'b0);
      end
    end

    // 3-stage sync, single-count: 2-cycle pulse appears after 4 edges
    bd = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    bl = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    br = '{1'b0, 1'b0, 1'b0, P,    1'b0, 1'b0, 1'b0};
    bf = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, P,    1'b0};
    for (int i = 0; i < 7; i++) begin
      sb.push_back('{i, 1'b1, bl[i], br[i], bf[i]});
      step(1'b0, 1'b0, bd[i]);
      chk("a_quiet", i, ifa.level_o, 1'b0);
    end

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard left %0d want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debounce_sync_filter.md
DEBOUNCE_SYNC_FILTER -- requirements
Module: debounce_sync_filter

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of synchronizer flops; legal range 2..4.
REQ-002 SHALL have parameter STABLE_CNT, default 16: consecutive synchronized cycles needed to accept a new level; legal range 1..255.
REQ-003 SHALL have parameter CNT_W, default 8: counter width; SHALL be at least ceil(log2(STABLE_CNT+1)).
REQ-004 SHALL flag an out-of-range SYNC_STAGES, STABLE_CNT or CNT_W as an elaboration error.
REQ-005 clk_i  input  1  single clock; all flops on its rising edge.
REQ-006 rst_i  input  1  synchronous reset, active-high.
REQ-007 data_i  input  1  raw asynchronous level, e.g. switch or pin.
REQ-008 level_o  output  1  debounced, synchronized level; feeds the downstream resettable/follower flop pair as its data input.
REQ-009 rise_o  output  1  one-cycle pulse on accepted 0->1 transition.
REQ-010 fall_o  output  1  one-cycle pulse on accepted 1->0 transition.

Function
REQ-011 Synchronizer chain SHALL be SYNC_STAGES non-resettable follower flops, coded in a procedural block separate from all resettable flops; sync = last stage.
REQ-012 FSM states SHALL be: LOW_STABLE, LOW_PEND, HIGH_STABLE, HIGH_PEND; level_o = 1 in HIGH_STABLE and HIGH_PEND, else 0.
REQ-013 LOW_STABLE with sync=1 -> LOW_PEND, cnt=1; otherwise hold, cnt=0.
REQ-014 LOW_PEND with sync=1: if cnt=STABLE_CNT-1 -> HIGH_STABLE, cnt=0; else cnt+1.
REQ-015 LOW_PEND with sync=0 (bounce) -> LOW_STABLE, cnt=0, same edge.
REQ-016 HIGH_STABLE, HIGH_PEND SHALL mirror REQ-013..015 with sync polarity inverted.
REQ-017 If STABLE_CNT=1, the _PEND state SHALL be skipped: _STABLE with sync differing -> opposite _STABLE directly.
REQ-018 Latency: level_o SHALL take the new value at rising edge number SYNC_STAGES+STABLE_CNT, counting the first edge that samples the new data_i as edge 1, with data_i held stable throughout.
REQ-019 Any data_i pulse shorter than STABLE_CNT cycles after synchronization SHALL leave level_o unchanged.
REQ-020 cnt SHALL never exceed STABLE_CNT-1; no wrap-around is reachable.
REQ-021 rise_o SHALL be 1 for exactly the cycle in which level_o first reads 1; fall_o likewise for 0; never both in the same cycle.
REQ-022 Outputs SHALL be registered; no combinational path from data_i to any output.

Reset
REQ-023 While rst_i=1: state=LOW_STABLE, cnt=0, level_o=0, rise_o=0, fall_o=0.
REQ-024 Blanking counter SHALL hold the FSM in LOW_STABLE for SYNC_STAGES cycles after rst_i deasserts, ignoring possibly-X sync.
REQ-025 Reset asserted mid-PEND SHALL abort the pending transition with no rise_o/fall_o pulse.
REQ-026 Synchronizer flops SHALL NOT be reset.

Configuration
REQ-027 Macro DEBOUNCE_EDGE_PULSE_EN defined: rise_o/fall_o generated per REQ-021.
REQ-028 Macro undefined: rise_o and fall_o tied to 0, ports still present; their logic removed; level_o behaviour unchanged.

Verification (defaults, macro defined unless stated)
REQ-029 Reset 3 cycles, data_i=1 held from deassert -> level_o stays 0 through blanking and rises on edge 18 after first sampling edge; rise_o=1 for that one cycle.
REQ-030 data_i=1 for 10 cycles then 0 -> level_o, rise_o, fall_o remain 0.
REQ-031 From level_o=1, data_i toggles 0 for 15 cycles, 1 for 1, then 0 held -> level_o falls 18 edges after the final 0 is first sampled; single fall_o pulse.
REQ-032 rst_i asserted during LOW_PEND at cnt=9 -> next cycle level_o=0, cnt=0, no pulses; clean restart after release.
REQ-033 STABLE_CNT=1, SYNC_STAGES=3 -> level_o follows a 2-cycle data_i pulse with 4-edge latency.
REQ-034 Macro undefined, repeat REQ-029 -> level_o identical, rise_o/fall_o constant 0.
